i2c_bus_arbiter: RTL and testbench

//  Shares one open-drain I2C bus (scl/sda) between NUM_REQ masters, e.g.
//  i2c_setup and i2c_poll inside a sensor wrapper.

---
 rtl/i2c_pkg.sv | 23 ++
 rtl/i2c_bus_arbiter_rr_pick.sv | 36 +++
 rtl/i2c_bus_arbiter.sv | 118 +++++++++++
 tb/tb_i2c_bus_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: bus arbiter state encoding and defaults, plus the
// device address constants used by the sensor wrappers.
package i2c_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_GAP   = 2'd2
  } arb_state_e;

  localparam int unsigned ARB_GAP_CYCLES_DEF     = 500;
  localparam int unsigned ARB_TIMEOUT_CYCLES_DEF = 2000000;

  localparam logic [6:0] I2C_ADDR_BME280 = 7'h76;
  localparam logic [6:0] I2C_ADDR_SHT3X  = 7'h44;
  localparam logic [6:0] I2C_ADDR_TMP117 = 7'h48;

  // First byte on the wire: 7-bit address followed by the R/W bit.
  function automatic logic [7:0] i2c_addr_byte(input logic [6:0] addr, input logic rd);
    return {addr, rd};
  endfunction

endpackage

// File: rtl/i2c_bus_arbiter_rr_pick.sv
// Combinational winner selection: optional fixed priority for requester 0,
// otherwise round-robin starting just after the last owner.
module rr_pick #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned OWNER_W = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [OWNER_W-1:0] i_last_owner,
  input  logic               i_priority0,
  output logic [OWNER_W-1:0] o_winner,
  output logic               o_valid
);

  int unsigned w_dist;
  int unsigned w_best;

  always_comb begin
    o_winner = '0;
    w_best   = NUM_REQ;
    w_dist   = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (i_req[i]) begin
        // Distance past last_owner, so the previous owner ranks last.
        w_dist = (i + 2 * NUM_REQ - 32'(i_last_owner) - 1) % NUM_REQ;
        if (w_dist < w_best) begin
          w_best   = w_dist;
          o_winner = OWNER_W'(i);
        end
      end
    end
    if (i_priority0 && i_req[0]) o_winner = '0;
  end

  assign o_valid = |i_req;

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Grants a shared open-drain I2C bus to one of NUM_REQ masters, enforces a
// bus-free gap between owners and revokes a hung owner after a timeout.
module i2c_bus_arbiter
  import i2c_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 3,
  parameter int unsigned PRIORITY0      = 1,
  parameter int unsigned GAP_CYCLES     = ARB_GAP_CYCLES_DEF,
  parameter int unsigned TIMEOUT_CYCLES = ARB_TIMEOUT_CYCLES_DEF,
  parameter int unsigned CNT_W          = 24,
  localparam int unsigned OWNER_W       = (NUM_REQ <= 2) ? 1 : $clog2(NUM_REQ)
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [NUM_REQ-1:0] i_done,
  input  logic [NUM_REQ-1:0] i_scl_oe_in,
  input  logic [NUM_REQ-1:0] i_sda_oe_in,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [OWNER_W-1:0] o_owner,
  output logic               o_busy,
  output logic               o_timeout,
  output logic               o_scl_oe,
  output logic               o_sda_oe
);

  if (longint'(TIMEOUT_CYCLES) >= (longint'(1) << CNT_W) ||
      longint'(GAP_CYCLES) >= (longint'(1) << CNT_W)) begin : g_bad_cnt_w
    $error("i2c_bus_arbiter: GAP_CYCLES/TIMEOUT_CYCLES do not fit in CNT_W bits");
  end
  if (GAP_CYCLES < 1 || NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_param
    $error("i2c_bus_arbiter: illegal GAP_CYCLES or NUM_REQ");
  end

  arb_state_e         r_state;
  logic [NUM_REQ-1:0] r_grant;
  logic [OWNER_W-1:0] r_owner;
  logic [OWNER_W-1:0] r_last;
  logic               r_busy;
  logic               r_timeout;
  logic [CNT_W-1:0]   r_cnt;

  logic [OWNER_W-1:0] w_winner;
  logic               w_valid;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_done;
  logic               w_abandon;
  logic               w_expire;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .OWNER_W (OWNER_W)
  ) u_rr_pick (
    .i_req        (i_req),
    .i_last_owner (r_last),
    .i_priority0  (PRIORITY0 != 0),
    .o_winner     (w_winner),
    .o_valid      (w_valid)
  );

  // r_grant is one-hot and only nonzero in GRANT, so masking selects the owner.
  assign w_done    = |(r_grant & i_done);
  assign w_abandon = |(r_grant & ~i_req);
  assign w_expire  = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= ARB_IDLE;
      r_grant   <= '0;
      r_owner   <= '0;
      r_last    <= OWNER_W'(NUM_REQ - 1);
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_timeout <= 1'b0;
      unique case (r_state)
        ARB_IDLE: begin
          if (w_valid) begin
            r_state <= ARB_GRANT;
            r_grant <= NUM_REQ'(1) << w_winner;
            r_owner <= w_winner;
            r_last  <= w_winner;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
          end
        end
        ARB_GRANT: begin
          if (w_done || w_abandon || w_expire) begin
            r_state   <= ARB_GAP;
            r_grant   <= '0;
            r_cnt     <= '0;
            r_timeout <= w_expire && !w_done;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        ARB_GAP: begin
          r_cnt <= w_cnt_inc;
          if (r_cnt == CNT_W'(GAP_CYCLES - 1)) begin
            r_state <= ARB_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  assign o_grant   = r_grant;
  assign o_owner   = r_owner;
  assign o_busy    = r_busy;
  assign o_timeout = r_timeout;
  assign o_scl_oe  = |(r_grant & i_scl_oe_in);
  assign o_sda_oe  = |(r_grant & i_sda_oe_in);

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Bench for i2c_bus_arbiter: a round-robin and a priority-0 instance share one
// stimulus stream and are compared against a cycle-level reference model.
module tb_i2c_bus_arbiter;

  localparam int N   = 3;
  localparam int GAP = 4;
  localparam int TMO = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] done = '0;
  logic [N-1:0] scl_in = '0;
  logic [N-1:0] sda_in = '0;

  logic [N-1:0] grant [2];
  logic [1:0]   owner [2];
  logic         busy  [2];
  logic         tmo   [2];
  logic         scl   [2];
  logic         sda   [2];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state, one entry per DUT (0: round-robin, 1: priority 0).
  bit m_active [2];
  int m_owner  [2];
  int m_last   [2];
  int m_held   [2];
  int m_free   [2];
  bit m_to     [2];

  always #5 clk = ~clk;

  i2c_bus_arbiter #(
    .NUM_REQ(N), .PRIORITY0(0), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO), .CNT_W(8)
  ) u_dut_rr (
    .i_clock(clk), .i_reset(rst), .i_req(req), .i_done(done),
    .i_scl_oe_in(scl_in), .i_sda_oe_in(sda_in),
    .o_grant(grant[0]), .o_owner(owner[0]), .o_busy(busy[0]), .o_timeout(tmo[0]),
    .o_scl_oe(scl[0]), .o_sda_oe(sda[0])
  );

  i2c_bus_arbiter #(
    .NUM_REQ(N), .PRIORITY0(1), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO), .CNT_W(8)
  ) u_dut_p0 (
    .i_clock(clk), .i_reset(rst), .i_req(req), .i_done(done),
    .i_scl_oe_in(scl_in), .i_sda_oe_in(sda_in),
    .o_grant(grant[1]), .o_owner(owner[1]), .o_busy(busy[1]), .o_timeout(tmo[1]),
    .o_scl_oe(scl[1]), .o_sda_oe(sda[1])
  );

  function automatic logic bitat(input logic [N-1:0] v, input int i);
    return ((v >> i) & 3'b001) != 3'b000;
  endfunction

  function automatic int pick(input int m);
    int idx;
    if (m == 1 && req[0]) return 0;
    for (int j = 1; j <= N; j++) begin
      idx = (m_last[m] + j) % N;
      if (bitat(req, idx)) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_active[m] = 1'b0;
      m_owner[m]  = 0;
      m_last[m]   = N - 1;
      m_held[m]   = 0;
      m_free[m]   = GAP + 1;
      m_to[m]     = 1'b0;
    end
  endtask

  task automatic model_edge();
    int  w;
    bit  d;
    if (rst) begin
      model_reset();
      return;
    end
    for (int m = 0; m < 2; m++) begin
      m_to[m] = 1'b0;
      if (m_active[m]) begin
        m_held[m]++;
        d = bitat(done, m_owner[m]);
        if (d || !bitat(req, m_owner[m]) || m_held[m] == TMO) begin
          m_active[m] = 1'b0;
          m_free[m]   = 0;
          m_to[m]     = (m_held[m] == TMO) && !d;
        end
      end else begin
        if (m_free[m] < 1000) m_free[m]++;
        w = pick(m);
        if (m_free[m] >= GAP + 1 && w >= 0) begin
          m_active[m] = 1'b1;
          m_owner[m]  = w;
          m_last[m]   = w;
          m_held[m]   = 0;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input int m);
    logic [N-1:0] eg;
    eg = m_active[m] ? (3'b001 << m_owner[m]) : 3'b000;
    chk($sformatf("grant%0d", m), 32'(grant[m]), 32'(eg));
    chk($sformatf("owner%0d", m), 32'(owner[m]), 32'(m_owner[m]));
    chk($sformatf("busy%0d", m), 32'(busy[m]), 32'(m_active[m] || m_free[m] < GAP));
    chk($sformatf("timeout%0d", m), 32'(tmo[m]), 32'(m_to[m]));
    chk($sformatf("scl_oe%0d", m), 32'(scl[m]), 32'(m_active[m] && bitat(scl_in, m_owner[m])));
    chk($sformatf("sda_oe%0d", m), 32'(sda[m]), 32'(m_active[m] && bitat(sda_in, m_owner[m])));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk_all(0);
    chk_all(1);
  endtask

  initial begin
    int n;
    logic [N-1:0] flip;
    model_reset();
    #12;
    chk_all(0);
    chk_all(1);
    chk("reset_grant", 32'(grant[0]), 32'd0);
    rst = 1'b0;

    // Round-robin first pick after reset.
    req = 3'b110;
    step();
    chk("t1_grant", 32'(grant[0]), 32'b010);
    chk("t1_owner", 32'(owner[0]), 32'd1);

    // Done from owner 1: gap of GAP+1 free cycles, then requester 2.
    done = 3'b010;
    step();
    done = 3'b000;
    chk("t2_free0", 32'(grant[0]), 32'd0);
    for (int k = 0; k < GAP; k++) begin
      step();
      chk("t2_free", 32'(grant[0]), 32'd0);
    end
    step();
    chk("t2_grant", 32'(grant[0]), 32'b100);
    chk("t2_owner", 32'(owner[0]), 32'd2);

    // Owner's sda passes through, non-owner's scl is ignored.
    sda_in = 3'b100;
    scl_in = 3'b010;
    step();
    chk("t5_sda", 32'(sda[0]), 32'd1);
    chk("t5_scl", 32'(scl[0]), 32'd0);

    // Timeout: grant must last exactly TMO cycles.
    done = 3'b100;
    req  = 3'b000;
    step();
    done = 3'b000;
    for (int k = 0; k < GAP + 1; k++) step();
    scl_in = 3'b111;
    sda_in = 3'b111;
    req    = 3'b001;
    step();
    n = 0;
    do begin
      step();
      n++;
    end while (grant[0] != 3'b000 && n < 40);
    chk("t4_len", 32'(n), 32'(TMO));
    chk("t4_pulse", 32'(tmo[0]), 32'd1);
    chk("t4_scl", 32'(scl[0]), 32'd0);
    step();
    chk("t4_pulse_end", 32'(tmo[0]), 32'd0);

    // Simultaneous req 0 and 2: priority instance takes 0, round-robin takes 2.
    req = 3'b000;
    for (int k = 0; k < GAP + 1; k++) step();
    req = 3'b101;
    step();
    chk("t3_p0_grant", 32'(grant[1]), 32'b001);
    chk("t3_rr_grant", 32'(grant[0]), 32'b100);
    done = 3'b001;
    req  = 3'b100;
    step();
    done = 3'b000;
    chk("t3_nonowner_done", 32'(grant[0]), 32'b100);
    for (int k = 0; k < GAP; k++) step();
    step();
    chk("t3_p0_next", 32'(grant[1]), 32'b100);

    // Asynchronous reset between edges releases the bus immediately.
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("t6_grant", 32'(grant[1]), 32'd0);
    chk("t6_scl", 32'(scl[1]), 32'd0);
    chk("t6_sda", 32'(sda[0]), 32'd0);
    chk_all(0);
    chk_all(1);
    step();
    rst = 1'b0;
    req = 3'b111;
    step();
    chk("t6_rr_first", 32'(grant[0]), 32'b001);
    chk("t6_p0_first", 32'(grant[1]), 32'b001);

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      flip[0] = ($urandom_range(31) == 0);
      flip[1] = ($urandom_range(31) == 0);
      flip[2] = ($urandom_range(31) == 0);
      req    = req ^ flip;
      done   = ($urandom_range(11) == 0) ? 3'(3'b001 << $urandom_range(2)) : 3'b000;
      scl_in = 3'($urandom);
      sda_in = 3'($urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
